// File: rtl/gcd_pkg.sv
// Shared parameters and state type for the GCD result path.
package gcd_pkg;
  localparam int DATA_W = 1284;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 12;
  localparam int NW     = (DATA_W + WORD_W - 1) / WORD_W;
  localparam int IDX_W  = $clog2(NW);
  localparam int PAD_W  = NW * WORD_W;
  localparam logic [3:0] HDR_MAGIC = 4'hA;

  typedef enum logic [1:0] {IDLE, HDR, SEND_A, SEND_B} unl_state_t;
endpackage

// File: rtl/gcd_word_select.sv
// Combinational slicer: returns word idx of an operand, zero above DATA_W.
module gcd_word_select
  import gcd_pkg::*;
(
  input  logic [DATA_W-1:0] operand,
  input  logic [IDX_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  logic [PAD_W-1:0] padded;

  assign padded = {{(PAD_W - DATA_W){1'b0}}, operand};

  always_comb begin
    word = '0;
    if (idx < IDX_W'(NW)) word = padded[idx*WORD_W +: WORD_W];
  end

endmodule

// File: rtl/gcd_result_unloader.sv
// Captures a finished GCD result and streams it as a header + A + B word frame.
//
// state  | meaning
// IDLE   | waiting for a rise of done
// HDR    | header word presented
// SEND_A | streaming cap_a words, LS first
// SEND_B | streaming cap_b words, m_last on the final one
module gcd_result_unloader
  import gcd_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clk_en,
  input  logic              done,
  input  logic [CNT_W-1:0]  cycle_count,
  input  logic [DATA_W-1:0] bezout_a,
  input  logic [DATA_W-1:0] bezout_b,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic              overrun,
  input  logic              clr_overrun
);

  unl_state_t        state;
  logic [IDX_W-1:0]  idx;
  logic              done_q;
  logic [CNT_W-1:0]  cap_cnt;
  logic [DATA_W-1:0] cap_a;
  logic [DATA_W-1:0] cap_b;
  logic              hdr_ovr;

  logic              rise;
  logic              xfer;
  logic              idx_end;
  logic [WORD_W-1:0] header;
  logic [WORD_W-1:0] op_word;

  assign rise    = done & ~done_q;
  assign xfer    = m_valid & m_ready;
  assign idx_end = (idx == IDX_W'(NW - 1));
  assign header  = {HDR_MAGIC, hdr_ovr, {(WORD_W - 5 - CNT_W){1'b0}}, cap_cnt};

  gcd_word_select u_word_select (
    .operand (state == SEND_B ? cap_b : cap_a),
    .idx     (idx),
    .word    (op_word)
  );

  always_comb begin
    m_data = '0;
    case (state)
      HDR:            m_data = header;
      SEND_A, SEND_B: m_data = op_word;
      default:        m_data = '0;
    endcase
  end

  assign m_last = (state == SEND_B) && idx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      done_q  <= 1'b0;
      cap_cnt <= '0;
      cap_a   <= '0;
      cap_b   <= '0;
      hdr_ovr <= 1'b0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else if (clk_en) begin
      done_q <= done;

      // A dropped result outranks a simultaneous clear.
      if (rise && state != IDLE) overrun <= 1'b1;
      else if (clr_overrun)      overrun <= 1'b0;

      case (state)
        IDLE: begin
          if (rise) begin
            cap_cnt <= cycle_count;
            cap_a   <= bezout_a;
            cap_b   <= bezout_b;
            hdr_ovr <= overrun;
            idx     <= '0;
            state   <= HDR;
            m_valid <= 1'b1;
            busy    <= 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            idx   <= '0;
            state <= SEND_A;
          end
        end
        SEND_A: begin
          if (xfer) begin
            if (idx_end) begin
              idx   <= '0;
              state <= SEND_B;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        SEND_B: begin
          if (xfer) begin
            if (idx_end) begin
              idx     <= '0;
              state   <= IDLE;
              m_valid <= 1'b0;
              busy    <= 1'b0;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gcd_result_unloader.sv
// Directed bench for gcd_result_unloader: frame content, backpressure, overrun, enable, reset.
module tb_gcd_result_unloader;

  logic          clk = 1'b0;
  logic          rst, clk_en, done, m_ready, clr_overrun;
  logic [11:0]   cycle_count;
  logic [1283:0] bezout_a, bezout_b;
  logic          m_valid, m_last, busy, overrun;
  logic [31:0]   m_data;

  int passed = 0;
  int total  = 0;

  logic [31:0]   got [0:127];
  logic [1283:0] exp_a, exp_b;
  logic [11:0]   exp_cnt;
  logic          exp_ovr;

  int   c_n, c_lasts, c_last_pos, c_unstable;
  logic c_timeout, c_v_at_rst;

  always #5 clk = ~clk;

  gcd_result_unloader dut (
    .clk         (clk),
    .rst         (rst),
    .clk_en      (clk_en),
    .done        (done),
    .cycle_count (cycle_count),
    .bezout_a    (bezout_a),
    .bezout_b    (bezout_b),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last),
    .busy        (busy),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  function automatic logic [31:0] exp_word(input int k);
    logic [1311:0] p;
    if (k == 0) return {4'hA, exp_ovr, 15'b0, exp_cnt};
    if (k <= 41) begin
      p = {28'b0, exp_a};
      return p[(k-1)*32 +: 32];
    end
    p = {28'b0, exp_b};
    return p[(k-42)*32 +: 32];
  endfunction

  function automatic int frame_errs(input int n);
    int e = 0;
    for (int k = 0; k < n; k++) if (got[k] !== exp_word(k)) e++;
    return e;
  endfunction

  // Enters and leaves on a negedge; records every word that will transfer on the next posedge.
  task automatic collect(input int rand_rdy, input int kind, input int evt_word);
    int   phase;
    logic pv, px, pl;
    logic [31:0] pd;
    bit   fin;
    c_n = 0; c_lasts = 0; c_last_pos = -1; c_unstable = 0;
    c_timeout = 1'b1; c_v_at_rst = 1'bx;
    phase = 0; pv = 1'b0; px = 1'b0; pl = 1'b0; pd = '0; fin = 1'b0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      if (kind == 1) begin
        if (phase == 0 && c_n == evt_word) begin
          done = 1'b0; cycle_count = 12'h777; bezout_a = '1; phase = 1;
        end else if (phase == 1) begin
          done = 1'b1; phase = 2;
        end
      end
      if (kind == 2) begin
        if (phase == 0 && c_n == evt_word) begin clk_en = 1'b0; phase = 1; end
        else if (phase >= 1 && phase < 5) phase++;
        else if (phase == 5) begin clk_en = 1'b1; phase = 6; end
      end
      if (kind == 3 && c_n == evt_word) begin
        rst = 1'b1;
        #1 c_v_at_rst = m_valid;
        #3 rst = 1'b0;
        c_timeout = 1'b0;
        return;
      end
      if (kind == 4 && c_n == 81) done = 1'b0;
      if ((kind == 4 || kind == 5) && c_n == 82) done = (kind == 4);
      m_ready = (rand_rdy != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (pv && !px && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) c_unstable++;
      pv = m_valid; pd = m_data; pl = m_last;
      px = m_valid && m_ready && clk_en;
      if (px) begin
        got[c_n] = m_data;
        if (m_last) begin c_lasts++; c_last_pos = c_n; fin = 1'b1; end
        c_n++;
        if (c_n >= 120) fin = 1'b1;
      end
      @(negedge clk);
    end
    if (fin) c_timeout = 1'b0;
    m_ready = 1'b1;
  endtask

  task automatic launch(input logic [11:0] cnt, input logic [1283:0] a, input logic [1283:0] b);
    done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    cycle_count = cnt; bezout_a = a; bezout_b = b;
    exp_cnt = cnt; exp_a = a; exp_b = b;
    done = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; clk_en = 1'b1; done = 1'b0; m_ready = 1'b1; clr_overrun = 1'b0;
    cycle_count = '0; bezout_a = '0; bezout_b = '0;
    @(negedge clk);
    total++; if (m_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", m_valid); else passed++;
    total++; if (m_data !== 32'h0) $display("FAIL reset_data: got %h want 0", m_data); else passed++;
    total++; if (m_last !== 1'b0) $display("FAIL reset_last: got %b want 0", m_last); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL idle_after_reset: valid %b busy %b want 0 0", m_valid, busy); else passed++;
  endtask

  task automatic test_basic_frame();
    logic [1283:0] b;
    int nz;
    b = '0; b[1283] = 1'b1;
    exp_ovr = 1'b0;
    launch(12'hFFF, 1284'd1, b);
    total++; if (m_valid !== 1'b1 || busy !== 1'b1) $display("FAIL hdr_latency: valid %b busy %b want 1 1", m_valid, busy); else passed++;
    total++; if (m_data !== 32'hA000_0FFF) $display("FAIL hdr_first_cycle: got %h want a0000fff", m_data); else passed++;
    collect(0, 0, 0);
    total++; if (c_timeout !== 1'b0 || c_n != 83) $display("FAIL basic_len: got %0d words timeout %b want 83", c_n, c_timeout); else passed++;
    total++; if (got[0] !== 32'hA000_0FFF) $display("FAIL basic_w0: got %h want a0000fff", got[0]); else passed++;
    total++; if (got[1] !== 32'h1) $display("FAIL basic_w1: got %h want 00000001", got[1]); else passed++;
    nz = 0;
    for (int k = 2; k < 82; k++) if (got[k] !== 32'h0) nz++;
    total++; if (nz != 0) $display("FAIL basic_zero_words: got %0d nonzero want 0", nz); else passed++;
    total++; if (got[82] !== 32'h0000_0008) $display("FAIL basic_w82: got %h want 00000008", got[82]); else passed++;
    total++; if (c_lasts != 1 || c_last_pos != 82) $display("FAIL basic_last: got %0d lasts at %0d want 1 at 82", c_lasts, c_last_pos); else passed++;
    total++; if (busy !== 1'b0 || m_valid !== 1'b0) $display("FAIL basic_idle: busy %b valid %b want 0 0", busy, m_valid); else passed++;
  endtask

  task automatic test_backpressure();
    logic [1283:0] a, b;
    for (int k = 0; k < 40; k++) begin
      a[k*32 +: 32] = 32'h0101_0101 * k + 32'h1;
      b[k*32 +: 32] = 32'hDEAD_0000 + k;
    end
    a[1283:1280] = 4'h9; b[1283:1280] = 4'h6;
    exp_ovr = 1'b0;
    launch(12'h5A5, a, b);
    collect(1, 0, 0);
    total++; if (c_timeout !== 1'b0 || c_n != 83) $display("FAIL bp_len: got %0d words timeout %b want 83", c_n, c_timeout); else passed++;
    total++; if (frame_errs(c_n) != 0) $display("FAIL bp_content: got %0d bad words want 0", frame_errs(c_n)); else passed++;
    total++; if (c_unstable != 0) $display("FAIL bp_stable: got %0d unstable cycles want 0", c_unstable); else passed++;
    total++; if (c_lasts != 1) $display("FAIL bp_last: got %0d lasts want 1", c_lasts); else passed++;
  endtask

  task automatic test_overrun();
    exp_ovr = 1'b0;
    launch(12'h123, 1284'h1234_5678_9ABC_DEF0, 1284'hCAFE);
    collect(0, 1, 10);
    total++; if (overrun !== 1'b1) $display("FAIL ovr_set: got %b want 1", overrun); else passed++;
    total++; if (c_n != 83 || frame_errs(c_n) != 0) $display("FAIL ovr_first_kept: %0d words %0d bad want 83 0", c_n, frame_errs(c_n)); else passed++;
    exp_ovr = 1'b1;
    launch(12'h456, 1284'h55, 1284'hAA);
    collect(0, 0, 0);
    total++; if (got[0] !== 32'hA800_0456) $display("FAIL ovr_hdr_bit27: got %h want a8000456", got[0]); else passed++;
    total++; if (c_n != 83 || frame_errs(c_n) != 0) $display("FAIL ovr_third: %0d words %0d bad want 83 0", c_n, frame_errs(c_n)); else passed++;
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    total++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b want 0", overrun); else passed++;
  endtask

  task automatic test_back_to_back();
    exp_ovr = 1'b0;
    launch(12'h0B2, 1284'h77, 1284'h88);
    collect(0, 4, 0);
    total++; if (overrun !== 1'b1) $display("FAIL b2b_same_edge_ovr: got %b want 1", overrun); else passed++;
    total++; if (m_valid !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_dropped: valid %b busy %b want 0 0", m_valid, busy); else passed++;
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    launch(12'h0B3, 1284'h99, 1284'h11);
    collect(0, 5, 0);
    done = 1'b1;
    @(negedge clk);
    total++; if (m_valid !== 1'b1 || overrun !== 1'b0) $display("FAIL b2b_next_edge: valid %b ovr %b want 1 0", m_valid, overrun); else passed++;
    collect(0, 0, 0);
    total++; if (c_n != 83 || frame_errs(c_n) != 0) $display("FAIL b2b_frame: %0d words %0d bad want 83 0", c_n, frame_errs(c_n)); else passed++;
  endtask

  task automatic test_clk_en();
    exp_ovr = 1'b0;
    launch(12'h321, 1284'h0102_0304_0506_0708_090A, 1284'h0B0C_0D0E_0F10);
    collect(0, 2, 20);
    total++; if (c_timeout !== 1'b0 || c_n != 83) $display("FAIL ce_len: got %0d words want 83", c_n); else passed++;
    total++; if (c_unstable != 0) $display("FAIL ce_frozen: got %0d changes want 0", c_unstable); else passed++;
    total++; if (frame_errs(c_n) != 0) $display("FAIL ce_content: got %0d bad words want 0", frame_errs(c_n)); else passed++;
  endtask

  task automatic test_reset_mid();
    exp_ovr = 1'b0;
    launch(12'hABC, 1284'h4444_3333_2222_1111, 1284'h8888_7777);
    collect(0, 3, 30);
    total++; if (c_v_at_rst !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", c_v_at_rst); else passed++;
    total++; if (c_n != 30 || c_lasts != 0) $display("FAIL rst_abandon: %0d words %0d lasts want 30 0", c_n, c_lasts); else passed++;
    @(negedge clk);
    collect(0, 0, 0);
    total++; if (c_n != 83 || c_lasts != 1) $display("FAIL rst_resend_len: %0d words %0d lasts want 83 1", c_n, c_lasts); else passed++;
    total++; if (frame_errs(c_n) != 0) $display("FAIL rst_resend_content: got %0d bad words want 0", frame_errs(c_n)); else passed++;
  endtask

  task automatic test_padding();
    exp_ovr = 1'b0;
    launch(12'h000, '1, '0);
    collect(0, 0, 0);
    total++; if (got[1] !== 32'hFFFF_FFFF || got[40] !== 32'hFFFF_FFFF) $display("FAIL pad_full: w1 %h w40 %h want ffffffff", got[1], got[40]); else passed++;
    total++; if (got[41] !== 32'h0000_000F) $display("FAIL pad_top: got %h want 0000000f", got[41]); else passed++;
    total++; if (c_n != 83 || frame_errs(c_n) != 0) $display("FAIL pad_frame: %0d words %0d bad want 83 0", c_n, frame_errs(c_n)); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_clk_en();
    test_reset_mid();
    test_padding();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
